// File: rtl/nunchuk_poller_if.sv
// nunchuk_poller_if
//   Command/status bus between the nunchuk poller and the I2C master.
//   Signals:
//     ctrl_data [31:0]  command word (poller -> master), held stable between commands
//     wr_ctrl           one-cycle command strobe (poller -> master)
//     read              read/write select (poller -> master), held for whole transaction
//     status    [31:0]  master status (master -> poller):
//                       [31] busy, [30] addr NACK, [29] data NACK, [28] read done, [7:0] data
//   Modports:
//     master  poller side (drives commands, consumes status)
//     slave   I2C master side (consumes commands, drives status)
interface nunchuk_poller_if;
    logic [31:0] ctrl_data;
    logic        wr_ctrl;
    logic        read;
    logic [31:0] status;

    modport master (
        output ctrl_data,
        output wr_ctrl,
        output read,
        input  status
    );

    modport slave (
        input  ctrl_data,
        input  wr_ctrl,
        input  read,
        output status
    );
endinterface

// File: rtl/nunchuk_poller.sv
// nunchuk_poller
//   Command sequencer sitting in front of the I2C master. Initialises a Wii
//   nunchuk, then polls its 6-byte report and publishes the decoded joystick,
//   accelerometer and button values atomically. Only one I2C transaction is
//   ever in flight.
//
// Parameters:
//   I2C_ADDR      7-bit slave address placed in ctrl_data[30:24]
//   POLL_CYCLES   cycles from end of one report to start of the next (>= 2)
//   RETRY_CYCLES  backoff cycles after any NACK before full re-init (>= 2)
//
// Ports:
//   sys_clock     system clock, shared with the I2C master
//   reset         asynchronous, active-high
//   enable        1 = run; 0 = finish current report, then idle in POLL_WAIT
//   bus           command/status bus to the I2C master (master modport)
//   joy_x, joy_y  joystick bytes
//   accel_x/y/z   10-bit accelerometer values
//   btn_c, btn_z  buttons, 1 = pressed
//   sample_valid  one-cycle pulse when all report outputs update together
//   error         sticky NACK flag, cleared by the next complete report
//   sample_count  number of published reports, wraps at 16'hFFFF
//
// Build option:
//   NUNCHUK_LEGACY_INIT_EN  single legacy init write (sub 8'h40, data 8'h00)
//                           and every captured byte decoded as
//                           (b ^ 8'h17) + 8'h17 before use.
//                           Undefined: two-write unencrypted init, raw bytes.
module nunchuk_poller #(
    parameter logic [6:0]  I2C_ADDR     = 7'h52,
    parameter int unsigned POLL_CYCLES  = 160000,
    parameter int unsigned RETRY_CYCLES = 1600000
) (
    input  logic                    sys_clock,
    input  logic                    reset,
    input  logic                    enable,
    nunchuk_poller_if.master        bus,
    output logic [7:0]              joy_x,
    output logic [7:0]              joy_y,
    output logic [9:0]              accel_x,
    output logic [9:0]              accel_y,
    output logic [9:0]              accel_z,
    output logic                    btn_c,
    output logic                    btn_z,
    output logic                    sample_valid,
    output logic                    error,
    output logic [15:0]             sample_count
);

    typedef enum logic [2:0] {
        S_WAIT_READY,
        S_STROBE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_CHECK,
        S_POLL_WAIT,
        S_BACKOFF
    } state_t;

    // Which command of the sequence is currently being issued.
    typedef enum logic [1:0] {
        PH_INIT0,
        PH_INIT1,
        PH_READ
    } phase_t;

    state_t      state, state_n;
    phase_t      phase, phase_n;
    logic [2:0]  rd_idx, rd_idx_n;
    logic [31:0] cnt, cnt_n;

    logic        load_cmd;
    logic        capture;
    logic        publish;
    logic        set_error;
    logic        wr_strobe;

    logic [31:0] ctrl_q;
    logic        read_q;
    logic [32:0] cmd_next;
    logic [7:0]  shadow [0:4];

    logic        busy;
    logic        nack;
    logic [7:0]  rx_byte;
    logic        unused_status;

    assign busy          = bus.status[31];
    assign nack          = bus.status[30] | bus.status[29];
    assign unused_status = ^bus.status[28:8];

    function automatic logic [7:0] decode_byte(input logic [7:0] b);
`ifdef NUNCHUK_LEGACY_INIT_EN
        return (b ^ 8'h17) + 8'h17;
`else
        return b;
`endif
    endfunction

    // Returns {read, ctrl_data} for a given step of the sequence.
    function automatic logic [32:0] command(input phase_t ph, input logic [2:0] idx);
        case (ph)
`ifdef NUNCHUK_LEGACY_INIT_EN
            PH_INIT0: return {1'b0, 1'b1, I2C_ADDR, 8'h40, 8'h00, 8'h00};
`else
            PH_INIT0: return {1'b0, 1'b1, I2C_ADDR, 8'hF0, 8'h55, 8'h00};
`endif
            PH_INIT1: return {1'b0, 1'b1, I2C_ADDR, 8'hFB, 8'h00, 8'h00};
            default:  return {1'b1, 1'b0, I2C_ADDR, 5'b0, idx, 16'h0000};
        endcase
    endfunction

    assign rx_byte  = decode_byte(bus.status[7:0]);
    assign cmd_next = command(phase_n, rd_idx_n);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state  <= S_WAIT_READY;
            phase  <= PH_INIT0;
            rd_idx <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            phase  <= phase_n;
            rd_idx <= rd_idx_n;
            cnt    <= cnt_n;
        end
    end

    // ------------------------------------------------------------------
    // Next state and control strobes
    // The command registers are loaded on the edge that leaves the
    // preceding state, so ctrl_data/read are already stable in S_STROBE
    // and wr_ctrl can fire in that same cycle. This also lets the last
    // POLL_WAIT cycle double as the command set-up cycle, giving exactly
    // POLL_CYCLES cycles from sample_valid to the next READ 0 strobe.
    // ------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        phase_n   = phase;
        rd_idx_n  = rd_idx;
        cnt_n     = cnt;
        load_cmd  = 1'b0;
        capture   = 1'b0;
        publish   = 1'b0;
        set_error = 1'b0;
        wr_strobe = 1'b0;

        case (state)
            S_WAIT_READY: begin
                // Master still starting up while busy is high.
                if (!busy) begin
                    phase_n  = PH_INIT0;
                    rd_idx_n = '0;
                    load_cmd = 1'b1;
                    state_n  = S_STROBE;
                end
            end

            S_STROBE: begin
                if (!busy) begin
                    wr_strobe = 1'b1;
                    state_n   = S_WAIT_BUSY;
                end
            end

            S_WAIT_BUSY: begin
                if (busy) state_n = S_WAIT_DONE;
            end

            S_WAIT_DONE: begin
                if (!busy) state_n = S_CHECK;
            end

            S_CHECK: begin
                if (nack) begin
                    set_error = 1'b1;
                    cnt_n     = RETRY_CYCLES - 1;
                    state_n   = S_BACKOFF;
                end else begin
                    case (phase)
                        PH_INIT0: begin
`ifdef NUNCHUK_LEGACY_INIT_EN
                            cnt_n   = '0;
                            state_n = S_POLL_WAIT;
`else
                            phase_n  = PH_INIT1;
                            load_cmd = 1'b1;
                            state_n  = S_STROBE;
`endif
                        end
                        PH_INIT1: begin
                            // Init done: first poll starts as soon as enable allows.
                            cnt_n   = '0;
                            state_n = S_POLL_WAIT;
                        end
                        default: begin
                            if (rd_idx == 3'd5) begin
                                // Byte 5 goes straight to the outputs with the shadow.
                                publish = 1'b1;
                                cnt_n   = POLL_CYCLES - 1;
                                state_n = S_POLL_WAIT;
                            end else begin
                                capture  = 1'b1;
                                rd_idx_n = rd_idx + 3'd1;
                                load_cmd = 1'b1;
                                state_n  = S_STROBE;
                            end
                        end
                    endcase
                end
            end

            S_POLL_WAIT: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 32'd1;
                end else if (enable && !busy) begin
                    phase_n  = PH_READ;
                    rd_idx_n = '0;
                    load_cmd = 1'b1;
                    state_n  = S_STROBE;
                end
            end

            S_BACKOFF: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 32'd1;
                end else if (!busy) begin
                    phase_n  = PH_INIT0;
                    rd_idx_n = '0;
                    load_cmd = 1'b1;
                    state_n  = S_STROBE;
                end
            end

            default: begin
                state_n = S_WAIT_READY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command registers, shadow capture and report publication
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            ctrl_q       <= '0;
            read_q       <= 1'b0;
            joy_x        <= '0;
            joy_y        <= '0;
            accel_x      <= '0;
            accel_y      <= '0;
            accel_z      <= '0;
            btn_c        <= 1'b0;
            btn_z        <= 1'b0;
            sample_valid <= 1'b0;
            error        <= 1'b0;
            sample_count <= '0;
            for (int unsigned i = 0; i < 5; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            sample_valid <= publish;

            if (load_cmd) begin
                {read_q, ctrl_q} <= cmd_next;
            end

            if (capture) begin
                shadow[rd_idx] <= rx_byte;
            end

            if (publish) begin
                joy_x        <= shadow[0];
                joy_y        <= shadow[1];
                accel_x      <= {shadow[2], rx_byte[3:2]};
                accel_y      <= {shadow[3], rx_byte[5:4]};
                accel_z      <= {shadow[4], rx_byte[7:6]};
                btn_c        <= ~rx_byte[1];
                btn_z        <= ~rx_byte[0];
                sample_count <= sample_count + 16'd1;
                read_q       <= 1'b0;
            end

            if (set_error) begin
                error <= 1'b1;
            end else if (publish) begin
                error <= 1'b0;
            end
        end
    end

    assign bus.ctrl_data = ctrl_q;
    assign bus.read      = read_q;
    assign bus.wr_ctrl   = wr_strobe;

endmodule
